// File: rtl/quant_dense_neuron_engine.sv
// Int8 dense-layer neuron: streams LANES-wide zero-point-corrected MAC beats, adds bias,
// optional ReLU, then Q31 requantization with round-half-up, output zero point and clamp.
module quant_dense_neuron_engine #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned LANES    = 4,
   parameter int unsigned ACC_W    = 32,
   parameter bit          SATURATE = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_relu_en,
   input  logic [DATA_W-1:0]       i_in_zp,
   input  logic [DATA_W-1:0]       i_w_zp,
   input  logic [DATA_W-1:0]       i_out_zp,
   input  logic [ACC_W-1:0]        i_bias,
   input  logic [31:0]             i_qmult,
   input  logic [7:0]              i_qshift,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [LANES*DATA_W-1:0] i_x,
   input  logic [LANES*DATA_W-1:0] i_w,
   input  logic [LANES-1:0]        i_mask,
   input  logic                    i_last,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_busy
);

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_BIAS, S_MULT, S_SHIFT, S_OUT} state_t;

   localparam logic signed [63:0] OMAX = (64'sd1 <<< (DATA_W-1)) - 64'sd1;
   localparam logic signed [63:0] OMIN = -(64'sd1 <<< (DATA_W-1));

   state_t                     state_q, state_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [ACC_W-1:0]    s_q, s_d;
   logic signed [63:0]         p_q, p_d;
   logic [DATA_W-1:0]          data_q, data_d;
   logic                       relu_q, relu_d;
   logic signed [DATA_W-1:0]   in_zp_q, in_zp_d, w_zp_q, w_zp_d, out_zp_q, out_zp_d;
   logic signed [ACC_W-1:0]    bias_q, bias_d;
   logic signed [31:0]         qmult_q, qmult_d;
   logic signed [7:0]          qshift_q, qshift_d;

   logic signed [ACC_W-1:0]    beat_sum, bias_sum;
   logic signed [9:0]          ts_raw;
   logic [5:0]                 ts;
   logic signed [63:0]         mult_rnd, r_shift;
   logic [DATA_W-1:0]          data_out;

   always_comb begin
      beat_sum = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         logic signed [DATA_W-1:0]   xk, wk;
         logic signed [DATA_W:0]     dx, dw;
         logic signed [2*DATA_W+1:0] prod;
         xk   = i_x[k*DATA_W +: DATA_W];
         wk   = i_w[k*DATA_W +: DATA_W];
         dx   = $signed({xk[DATA_W-1], xk}) - $signed({in_zp_q[DATA_W-1], in_zp_q});
         dw   = $signed({wk[DATA_W-1], wk}) - $signed({w_zp_q[DATA_W-1], w_zp_q});
         prod = dx * dw;
         if (i_mask[k]) beat_sum = beat_sum + ACC_W'(prod);
      end

      bias_sum = acc_q + bias_q;
      if (relu_q && bias_sum[ACC_W-1]) bias_sum = '0;

      // Shift amount derived from the latched qshift and clamped to [1,62].
      ts_raw = 10'sd31 - 10'(qshift_q);
      if (ts_raw < 10'sd1)       ts = 6'd1;
      else if (ts_raw > 10'sd62) ts = 6'd62;
      else                       ts = ts_raw[5:0];

      mult_rnd = 64'(s_q) * 64'(qmult_q) + (64'sd1 <<< (ts - 6'd1));
      r_shift  = (p_q >>> ts) + 64'(out_zp_q);

      data_out = r_shift[DATA_W-1:0];
      if (SATURATE) begin
         if (r_shift > OMAX)      data_out = {1'b0, {(DATA_W-1){1'b1}}};
         else if (r_shift < OMIN) data_out = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      s_d      = s_q;
      p_d      = p_q;
      data_d   = data_q;
      relu_d   = relu_q;
      in_zp_d  = in_zp_q;
      w_zp_d   = w_zp_q;
      out_zp_d = out_zp_q;
      bias_d   = bias_q;
      qmult_d  = qmult_q;
      qshift_d = qshift_q;
      o_ready  = 1'b0;
      o_valid  = 1'b0;
      o_busy   = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: if (i_start) begin
            relu_d   = i_relu_en;
            in_zp_d  = i_in_zp;
            w_zp_d   = i_w_zp;
            out_zp_d = i_out_zp;
            bias_d   = i_bias;
            qmult_d  = i_qmult;
            qshift_d = i_qshift;
            acc_d    = '0;
            state_d  = S_ACCUM;
         end
         S_ACCUM: begin
            o_ready = 1'b1;
            if (i_valid) begin
               acc_d = acc_q + beat_sum;
               if (i_last) state_d = S_BIAS;
            end
         end
         S_BIAS: begin
            s_d     = bias_sum;
            state_d = S_MULT;
         end
         S_MULT: begin
            p_d     = mult_rnd;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            data_d  = data_out;
            state_d = S_OUT;
         end
         S_OUT: begin
            o_valid = 1'b1;
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         s_q      <= '0;
         p_q      <= '0;
         data_q   <= '0;
         relu_q   <= 1'b0;
         in_zp_q  <= '0;
         w_zp_q   <= '0;
         out_zp_q <= '0;
         bias_q   <= '0;
         qmult_q  <= '0;
         qshift_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         s_q      <= s_d;
         p_q      <= p_d;
         data_q   <= data_d;
         relu_q   <= relu_d;
         in_zp_q  <= in_zp_d;
         w_zp_q   <= w_zp_d;
         out_zp_q <= out_zp_d;
         bias_q   <= bias_d;
         qmult_q  <= qmult_d;
         qshift_q <= qshift_d;
      end
   end

   assign o_data = data_q;

endmodule

// File: tb/tb_quant_dense_neuron_engine.sv
// Bench for quant_dense_neuron_engine: saturating and wrapping instances share stimulus,
// results compared against an integer-arithmetic reference model.
module tb_quant_dense_neuron_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start, i_relu_en, i_valid, i_last, i_ready;
   logic [7:0]  i_in_zp, i_w_zp, i_out_zp, i_qshift;
   logic [31:0] i_bias, i_qmult, i_x, i_w;
   logic [3:0]  i_mask;
   logic        ready_s, valid_s, busy_s, ready_n, valid_n, busy_n;
   logic [7:0]  data_s, data_n;

   always #5 clk = ~clk;

   quant_dense_neuron_engine #(.DATA_W(8), .LANES(4), .ACC_W(32), .SATURATE(1'b1)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_relu_en(i_relu_en),
      .i_in_zp(i_in_zp), .i_w_zp(i_w_zp), .i_out_zp(i_out_zp), .i_bias(i_bias),
      .i_qmult(i_qmult), .i_qshift(i_qshift), .i_valid(i_valid), .o_ready(ready_s),
      .i_x(i_x), .i_w(i_w), .i_mask(i_mask), .i_last(i_last), .o_valid(valid_s),
      .i_ready(i_ready), .o_data(data_s), .o_busy(busy_s));

   quant_dense_neuron_engine #(.DATA_W(8), .LANES(4), .ACC_W(32), .SATURATE(1'b0)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_relu_en(i_relu_en),
      .i_in_zp(i_in_zp), .i_w_zp(i_w_zp), .i_out_zp(i_out_zp), .i_bias(i_bias),
      .i_qmult(i_qmult), .i_qshift(i_qshift), .i_valid(i_valid), .o_ready(ready_n),
      .i_x(i_x), .i_w(i_w), .i_mask(i_mask), .i_last(i_last), .o_valid(valid_n),
      .i_ready(i_ready), .o_data(data_n), .o_busy(busy_n));

   int checks = 0;
   int errors = 0;

   bit                 c_relu;
   logic signed [7:0]  c_in_zp, c_w_zp, c_out_zp, c_qshift;
   logic signed [31:0] c_bias, c_qmult;
   logic [31:0]        bx[32], bw[32];
   logic [3:0]         bm[32];
   int                 nb;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint lane(input logic [31:0] v, input int k);
      logic signed [7:0] e;
      e = v[k*8 +: 8];
      return longint'(e);
   endfunction

   // Reference: plain integer arithmetic over the whole vector.
   function automatic logic [7:0] model(input bit sat);
      longint acc, s, p, r;
      int ts;
      logic [63:0] rv;
      acc = 0;
      for (int b = 0; b < nb; b++)
         for (int k = 0; k < 4; k++)
            if (bm[b][k])
               acc += (lane(bx[b], k) - longint'(c_in_zp)) * (lane(bw[b], k) - longint'(c_w_zp));
      s = longint'(int'(acc)) + longint'(c_bias);
      s = longint'(int'(s));
      if (c_relu && s < 0) s = 0;
      ts = 31 - int'(c_qshift);
      if (ts < 1) ts = 1;
      if (ts > 62) ts = 62;
      p = s * longint'(c_qmult) + (longint'(1) <<< (ts - 1));
      r = (p >>> ts) + longint'(c_out_zp);
      if (sat) begin
         if (r > 127) r = 127;
         if (r < -128) r = -128;
      end
      rv = r;
      return rv[7:0];
   endfunction

   task automatic rand_cfg();
      c_relu   = 1'($urandom_range(0, 1));
      c_in_zp  = 8'($urandom);
      c_w_zp   = 8'($urandom);
      c_out_zp = 8'($urandom);
      c_bias   = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 4000)) - 32'd2000;
      c_qmult  = 32'($urandom);
      c_qshift = 8'($urandom_range(0, 80) - 40);
   endtask

   task automatic base_cfg();
      c_relu = 1'b0; c_in_zp = '0; c_w_zp = '0; c_out_zp = '0;
      c_bias = '0; c_qmult = 32'h7FFF_FFFF; c_qshift = '0;
   endtask

   task automatic start_neuron();
      @(negedge clk);
      check("idle_busy", {63'd0, busy_s}, 64'd0);
      i_relu_en = c_relu; i_in_zp = c_in_zp; i_w_zp = c_w_zp; i_out_zp = c_out_zp;
      i_bias = c_bias; i_qmult = c_qmult; i_qshift = c_qshift;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      // Scramble config inputs: the latched copy must be what the neuron uses.
      i_relu_en = ~c_relu; i_in_zp = 8'($urandom); i_w_zp = 8'($urandom);
      i_out_zp = 8'($urandom); i_bias = $urandom; i_qmult = $urandom; i_qshift = 8'($urandom);
      check("accum_ready", {63'd0, ready_s}, 64'd1);
   endtask

   task automatic send_beats(input int upto, input bit gaps);
      for (int b = 0; b < upto; b++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            i_valid = 1'b0; i_x = $urandom; i_w = $urandom; i_mask = 4'hF; i_last = 1'b1;
            @(negedge clk);
         end
         i_valid = 1'b1; i_x = bx[b]; i_w = bw[b]; i_mask = bm[b]; i_last = (b == nb - 1);
         @(negedge clk);
      end
   endtask

   task automatic finish_neuron(input string tag, input int hold, input bit poke,
                                input int k_sat, input int k_wrap);
      int lat;
      logic [7:0] e_s, e_n;
      i_valid = poke; i_last = poke;
      lat = 0;
      while (!valid_s && lat < 10) begin
         check({tag, "_busy_ready"}, {63'd0, ready_s}, 64'd0);
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd3);
      e_s = model(1'b1);
      e_n = model(1'b0);
      check({tag, "_sat"}, {56'd0, data_s}, {56'd0, e_s});
      check({tag, "_wrap"}, {56'd0, data_n}, {56'd0, e_n});
      check({tag, "_valid_wrap"}, {63'd0, valid_n}, 64'd1);
      if (k_sat >= 0)  check({tag, "_sat_const"}, {56'd0, data_s}, 64'(k_sat));
      if (k_wrap >= 0) check({tag, "_wrap_const"}, {56'd0, data_n}, 64'(k_wrap));
      i_valid = 1'b0; i_last = 1'b0;
      for (int h = 0; h < hold; h++) begin
         i_ready = 1'b0;
         i_start = poke;
         @(negedge clk);
         check({tag, "_hold_valid"}, {63'd0, valid_s}, 64'd1);
         check({tag, "_hold_data"}, {56'd0, data_s}, {56'd0, e_s});
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check({tag, "_done_valid"}, {63'd0, valid_s}, 64'd0);
      check({tag, "_done_busy"}, {62'd0, busy_s, busy_n}, 64'd0);
   endtask

   task automatic setup_t1();
      base_cfg();
      c_qmult = 32'h4000_0000; c_out_zp = 8'sd3;
      nb = 1; bx[0] = 32'h0403_0201; bw[0] = 32'h0101_0101; bm[0] = 4'hF;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; i_start = 0; i_relu_en = 0; i_valid = 0; i_last = 0; i_ready = 0;
      i_in_zp = 0; i_w_zp = 0; i_out_zp = 0; i_qshift = 0; i_bias = 0; i_qmult = 0;
      i_x = 0; i_w = 0; i_mask = 0;
      #3;
      check("rst_outputs", {52'd0, ready_s, valid_s, busy_s, data_s, ready_n}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      setup_t1();
      start_neuron(); send_beats(1, 1'b0); finish_neuron("t1", 0, 1'b0, 8, 8);

      base_cfg();
      c_relu = 1'b1; c_qmult = 32'h4000_0000; c_out_zp = -8'sd5;
      nb = 1; bx[0] = 32'hF6F6_F6F6; bw[0] = 32'h0101_0101; bm[0] = 4'hF;
      start_neuron(); send_beats(1, 1'b0); finish_neuron("t2_relu", 0, 1'b0, 8'hFB, 8'hFB);

      c_relu = 1'b0; c_qmult = 32'h7FFF_FFFF; c_out_zp = '0;
      start_neuron(); send_beats(1, 1'b0); finish_neuron("t2_norelu", 0, 1'b0, 8'hD8, 8'hD8);

      base_cfg();
      nb = 10;
      for (int b = 0; b < 10; b++) begin bx[b] = 32'h1919_1919; bw[b] = 32'h0101_0101; bm[b] = 4'hF; end
      start_neuron(); send_beats(10, 1'b1); finish_neuron("t3_acc1000", 1, 1'b0, 8'h7F, 8'hE8);

      base_cfg();
      c_in_zp = -8'sd128; c_w_zp = 8'($urandom); c_bias = 32'sd77;
      nb = 3;
      for (int b = 0; b < 3; b++) begin bx[b] = 32'h8080_8080; bw[b] = $urandom; bm[b] = 4'hF; end
      bx[2] = 32'h7F7F_8080; bm[2] = 4'b0011;
      start_neuron(); send_beats(3, 1'b0); finish_neuron("t4_mask", 0, 1'b0, 77, 77);

      rand_cfg();
      nb = 2;
      for (int b = 0; b < 2; b++) begin bx[b] = $urandom; bw[b] = $urandom; bm[b] = 4'hF; end
      start_neuron(); send_beats(2, 1'b0); finish_neuron("t5_stall", 5, 1'b1, -1, -1);

      for (int it = 0; it < 25; it++) begin
         rand_cfg();
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin bx[b] = $urandom; bw[b] = $urandom; bm[b] = 4'($urandom); end
         start_neuron();
         send_beats(nb, 1'b1);
         finish_neuron("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, -1);
      end

      base_cfg();
      c_bias = 32'sd55;
      nb = 4;
      for (int b = 0; b < 4; b++) begin bx[b] = $urandom; bw[b] = $urandom; bm[b] = 4'hF; end
      start_neuron(); send_beats(3, 1'b0);
      #2 rst = 1'b1; i_valid = 1'b0;
      #1;
      check("t6_rst_sat", {53'd0, ready_s, valid_s, busy_s, data_s}, 64'd0);
      check("t6_rst_wrap", {53'd0, ready_n, valid_n, busy_n, data_n}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      setup_t1();
      start_neuron(); send_beats(1, 1'b0); finish_neuron("t6_rerun", 0, 1'b0, 8, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
